// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and parameter legality check for serial_adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    function automatic bit params_ok(input int width, input int digit);
        return width >= 2 && digit >= 1 && (width % digit) == 0;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-wide adder slice used by serial_adder.
//   a, b    : DIGIT-bit addends
//   cin     : carry in
//   s       : DIGIT-bit sum
//   cout    : carry out of the top bit
//   msb_cin : carry into the top bit (only with SERIAL_ADDER_OVF_EN)
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             msb_cin
`endif
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + (DIGIT+1)'(cin);

`ifdef SERIAL_ADDER_OVF_EN
    // sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly
    assign msb_cin = s[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
`endif

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, {cout,sum} = a + b + cin over WIDTH/DIGIT cycles.
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   start_i          : request, honoured in S_IDLE and S_DONE
//   a_i, b_i, cin_i  : operands, captured on the accepting edge
//   busy_o           : high while in S_RUN
//   done_o           : one-cycle result-valid pulse
//   sum_o, cout_o    : last completed result, held until the next completion
//   ovf_o            : last completed two's-complement overflow (macro SERIAL_ADDER_OVF_EN)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] ds;
    logic             dc;
    logic [WIDTH-1:0] acc_nxt;
    logic             last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             msb_c;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a      (a_q[DIGIT-1:0]),
        .b      (b_q[DIGIT-1:0]),
        .cin    (c_q),
        .s      (ds),
        .cout   (dc)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .msb_cin(msb_c)
`endif
    );

    // new digit enters at the top; after STEPS shifts the LSB digit lands at bit 0
    assign acc_nxt = WIDTH'({ds, acc} >> DIGIT);
    assign last    = cnt == CW'(STEPS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            sum_o  <= '0;
            cout_o <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_o  <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    a_q <= a_q >> DIGIT;
                    b_q <= b_q >> DIGIT;
                    c_q <= dc;
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        sum_o  <= acc_nxt;
                        cout_o <= dc;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_o  <= dc ^ msb_c;
`endif
                    end
                end
                default: begin
                    // S_IDLE and S_DONE accept a request identically
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_q    <= a_i;
                        b_q    <= b_i;
                        c_q    <= cin_i;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (8/1 and 16/4 instances).
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, cin_i, busy_o, done_o, cout_o;
    logic [7:0]  a_i, b_i, sum_o;
    logic        start2, cin2, busy2, done2, cout2;
    logic [15:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf_o, ovf2;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_sum;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o), .cout_o(cout_o)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_o(ovf_o)
`endif
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .a_i(a2), .b_i(b2), .cin_i(cin2),
        .busy_o(busy2), .done_o(done2), .sum_o(sum2), .cout_o(cout2)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_o(ovf2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one op on the 8-bit instance; poke pulses start_i mid-RUN, which must be ignored
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo, input logic poke);
        int n;
        a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
        chk({tag, " busy"}, busy_o, 1);
        n = 0;
        while (!done_o && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) begin
                chk({tag, " hold"}, sum_o, prev_sum);
                start_i = poke;
            end else start_i = 1'b0;
        end
        chk({tag, " latency"}, n, 8);
        chk({tag, " sum"}, sum_o, es);
        chk({tag, " cout"}, cout_o, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, " ovf"}, ovf_o, eo);
`endif
        prev_sum = es;
        @(posedge clk); #1;
        chk({tag, " done drop"}, done_o, 0);
        chk({tag, " idle"}, busy_o, 0);
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input logic eo);
        int n;
        a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, 4);
        chk({tag, " sum"}, sum2, es);
        chk({tag, " cout"}, cout2, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, " ovf"}, ovf2, eo);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int m;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] rs;
        rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        prev_sum = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        chk("reset sum", sum_o, 0);
        chk("reset cout", cout_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8("basic", 8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0);
        op8("wrap", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        op8("ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);

        // start_i held high: second op accepted in the S_DONE cycle
        a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        m = 0;
        while (!done_o && m < 20) begin
            @(posedge clk); #1;
            m++;
        end
        chk("b2b first latency", m, 8);
        chk("b2b first sum", sum_o, 8'h30);
        a_i = 8'h01; b_i = 8'h02;
        @(posedge clk); #1;
        m = 1;
        chk("b2b accepted", busy_o, 1);
        chk("b2b done drop", done_o, 0);
        chk("b2b hold", sum_o, 8'h30);
        while (!done_o && m < 20) begin
            @(posedge clk); #1;
            m++;
        end
        start_i = 1'b0;
        chk("b2b period", m, 9);
        chk("b2b second sum", sum_o, 8'h03);
        @(posedge clk); #1;
        chk("b2b idle", busy_o, 0);

        // asynchronous reset in the middle of RUN
        a_i = 8'hFF; b_i = 8'h01; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst sum", sum_o, 0);
        chk("rst cout", cout_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done_o) m++;
        end
        chk("rst no done", m, 0);
        chk("rst stays idle", busy_o, 0);

        op16("digit", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("digit ovf", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            rs = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            op16("rand", ra, rb, rc, rs[15:0], rs[16], (ra[15] == rb[15]) && (rs[15] != ra[15]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
